svga_timing: RTL and testbench

Generates the 800x600@60 Hz SVGA raster (40 MHz pixel clock) for the sprite display core. It provides the horizontal and vertical position counters that the sprite renderer reads. It also provides the blanking, data-enable and sync outputs that are driven to the Tiny VGA PMOD. The line and frame strobes it produces pace sprite line fetches and frame-level register updates.

---
 rtl/svga_timing.sv | 123 ++++++++++++
 tb/tb_svga_timing.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/svga_timing.sv
// 800x600@60 SVGA raster generator: position counters, blanks, data enable, syncs and line/frame strobes.
// Optional macro SVGA_SYNC_DELAY_EN delays hsync/vsync by one clock to match a one-stage pixel pipeline.
module svga_timing #(
  parameter int H_VISIBLE  = 800,
  parameter int H_FRONT    = 40,
  parameter int H_SYNC     = 128,
  parameter int H_BACK     = 88,
  parameter int V_VISIBLE  = 600,
  parameter int V_FRONT    = 1,
  parameter int V_SYNC     = 4,
  parameter int V_BACK     = 23,
  parameter bit H_SYNC_POL = 1'b1,
  parameter bit V_SYNC_POL = 1'b1,
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int HW        = $clog2(H_TOTAL),
  localparam int VW        = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [HW-1:0] counter_h,
  output logic [VW-1:0] counter_v,
  output logic          hblank,
  output logic          vblank,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          next_vertical,
  output logic          next_frame
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_C  = HW'(H_VISIBLE);
  localparam logic [VW-1:0] V_VIS_C  = VW'(V_VISIBLE);
  localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          hblank_q, hblank_d;
  logic          vblank_q, vblank_d;
  logic          de_q, de_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          nv_q, nv_d;
  logic          nf_q, nf_d;

  // Flags are decoded from the next counter value so each registered flag
  // lines up with the counter value presented in the same cycle.
  always_comb begin
    h_d = h_q + HW'(1);
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
    end
    hblank_d = (h_d >= H_VIS_C);
    vblank_d = (v_d >= V_VIS_C);
    de_d     = !hblank_d && !vblank_d;
    hsync_d  = ((h_d >= HS_START) && (h_d <= HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d  = ((v_d >= VS_START) && (v_d <= VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
    nv_d     = (h_d == H_LAST);
    nf_d     = nv_d && (v_d == V_LAST);
  end

  // Reset parks the counters on the last position so the first edge lands on (0,0).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_q      <= H_LAST;
      v_q      <= V_LAST;
      hblank_q <= 1'b1;
      vblank_q <= 1'b1;
      de_q     <= 1'b0;
      hsync_q  <= ~H_SYNC_POL;
      vsync_q  <= ~V_SYNC_POL;
      nv_q     <= 1'b0;
      nf_q     <= 1'b0;
    end else begin
      h_q      <= h_d;
      v_q      <= v_d;
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      de_q     <= de_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      nv_q     <= nv_d;
      nf_q     <= nf_d;
    end
  end

`ifdef SVGA_SYNC_DELAY_EN
  logic hsync_dly_q;
  logic vsync_dly_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync_dly_q <= ~H_SYNC_POL;
      vsync_dly_q <= ~V_SYNC_POL;
    end else begin
      hsync_dly_q <= hsync_q;
      vsync_dly_q <= vsync_q;
    end
  end

  assign hsync = hsync_dly_q;
  assign vsync = vsync_dly_q;
`else
  assign hsync = hsync_q;
  assign vsync = vsync_q;
`endif

  assign counter_h     = h_q;
  assign counter_v     = v_q;
  assign hblank        = hblank_q;
  assign vblank        = vblank_q;
  assign de            = de_q;
  assign next_vertical = nv_q;
  assign next_frame    = nf_q;

endmodule

// File: tb/tb_svga_timing.sv
// Bench for svga_timing: default 800x600 instance plus a reduced-geometry instance so full frames fit
// in a short run; both are checked every cycle against a position-from-edge-count reference model.
module tb_svga_timing;

  typedef struct packed {
    int hvis; int hf; int hs; int hb;
    int vvis; int vf; int vs; int vb;
    bit hpol; bit vpol;
  } tim_t;

  typedef struct packed {
    int h; int v;
    bit de; bit hb; bit vb; bit hs; bit vs; bit nv; bit nf;
  } exp_t;

  typedef struct {
    longint k; int h; int v;
    bit de; bit hb; bit vb; bit hs; bit vs; bit nv; bit nf;
  } row_t;

  localparam tim_t DP = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
  localparam tim_t SP = '{16, 4, 8, 4, 12, 1, 2, 3, 1'b0, 1'b1};
  localparam int S_HT    = 16 + 4 + 8 + 4;
  localparam int S_VT    = 12 + 1 + 2 + 3;
  localparam int S_FRAME = S_HT * S_VT;
`ifdef SVGA_SYNC_DELAY_EN
  localparam bit DLY = 1'b1;
`else
  localparam bit DLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] d_h;
  logic [9:0]  d_v;
  logic        d_hb, d_vb, d_de, d_hs, d_vs, d_nv, d_nf;
  logic [4:0]  s_h;
  logic [4:0]  s_v;
  logic        s_hb, s_vb, s_de, s_hs, s_vs, s_nv, s_nf;

  svga_timing u_def (
    .clk(clk), .reset_n(reset_n), .counter_h(d_h), .counter_v(d_v),
    .hblank(d_hb), .vblank(d_vb), .de(d_de), .hsync(d_hs), .vsync(d_vs),
    .next_vertical(d_nv), .next_frame(d_nf)
  );

  svga_timing #(
    .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_VISIBLE(12), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b1)
  ) u_sm (
    .clk(clk), .reset_n(reset_n), .counter_h(s_h), .counter_v(s_v),
    .hblank(s_hb), .vblank(s_vb), .de(s_de), .hsync(s_hs), .vsync(s_vs),
    .next_vertical(s_nv), .next_frame(s_nf)
  );

  int tests = 0;
  int fails = 0;
  int scan_n = 0;
  int scan_err = 0;
  bit scan_en = 1'b0;
  bit agg_on = 1'b0;
  int agg_nf = 0, agg_nv = 0, agg_de = 0, agg_vs = 0, agg_hs = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  // Rising edges seen since reset was released; 0 while in reset.
  longint k = 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) k <= 0;
    else          k <= k + 1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (k=%0d t=%0t)", name, act, exp, k, $time);
    end
  endtask

  function automatic bit sync_of(input int p, input int vis, input int fr, input int sw, input bit pol);
    return (p >= vis + fr && p < vis + fr + sw) ? pol : !pol;
  endfunction

  // Raster position after k edges: the (k-1)th pixel of the frame sequence.
  function automatic exp_t ref_at(input tim_t p, input longint kk);
    exp_t e;
    int ht, vt;
    longint pos;
    ht = p.hvis + p.hf + p.hs + p.hb;
    vt = p.vvis + p.vf + p.vs + p.vb;
    if (kk == 0) begin
      e.h = ht - 1; e.v = vt - 1; e.de = 0; e.hb = 1; e.vb = 1;
      e.hs = !p.hpol; e.vs = !p.vpol; e.nv = 0; e.nf = 0;
    end else begin
      pos  = (kk - 1) % (ht * vt);
      e.h  = int'(pos % ht);
      e.v  = int'(pos / ht);
      e.hb = (e.h >= p.hvis);
      e.vb = (e.v >= p.vvis);
      e.de = !e.hb && !e.vb;
      e.hs = sync_of(e.h, p.hvis, p.hf, p.hs, p.hpol);
      e.vs = sync_of(e.v, p.vvis, p.vf, p.vs, p.vpol);
      e.nv = (e.h == ht - 1);
      e.nf = e.nv && (e.v == vt - 1);
    end
`ifdef SVGA_SYNC_DELAY_EN
    if (kk <= 1) begin
      e.hs = !p.hpol; e.vs = !p.vpol;
    end else begin
      pos  = (kk - 2) % (ht * vt);
      e.hs = sync_of(int'(pos % ht), p.hvis, p.hf, p.hs, p.hpol);
      e.vs = sync_of(int'(pos / ht), p.vvis, p.vf, p.vs, p.vpol);
    end
`endif
    return e;
  endfunction

  function automatic exp_t act_def();
    exp_t e;
    e.h = int'(d_h); e.v = int'(d_v); e.de = d_de; e.hb = d_hb; e.vb = d_vb;
    e.hs = d_hs; e.vs = d_vs; e.nv = d_nv; e.nf = d_nf;
    return e;
  endfunction

  function automatic exp_t act_sm();
    exp_t e;
    e.h = int'(s_h); e.v = int'(s_v); e.de = s_de; e.hb = s_hb; e.vb = s_vb;
    e.hs = s_hs; e.vs = s_vs; e.nv = s_nv; e.nf = s_nf;
    return e;
  endfunction

  // Every-cycle scan of both instances plus frame statistics for the small one.
  always @(negedge clk) begin
    if (scan_en) begin
      exp_t ed, es, ad, as_;
      ed = ref_at(DP, k); es = ref_at(SP, k);
      ad = act_def();     as_ = act_sm();
      scan_n++;
      if (ad != ed) begin
        scan_err++;
        if (scan_err <= 8) $display("diff def k=%0d act=%h exp=%h", k, ad, ed);
      end
      if (as_ != es) begin
        scan_err++;
        if (scan_err <= 8) $display("diff sm k=%0d act=%h exp=%h", k, as_, es);
      end
      if (agg_on && k >= 1 && k <= 2 * S_FRAME) begin
        if (s_nf) begin agg_nf++; got_q.push_back(32'(k)); end
        if (s_nv) agg_nv++;
        if (s_de) agg_de++;
        if (s_vs == SP.vpol) agg_vs++;
        if (s_hs == SP.hpol) agg_hs++;
      end
    end
  end

  task automatic wait_k(input longint target);
    int g = 0;
    while (k < target && g < 200000) begin
      @(posedge clk); #2;
      g++;
    end
    check("wait_k", k, target);
  endtask

  row_t rows[12];

  initial begin
    exp_t e;
    rows[0]  = '{1,    0,    0, 1, 0, 0, 0,    0, 0, 0};
    rows[1]  = '{800,  799,  0, 1, 0, 0, 0,    0, 0, 0};
    rows[2]  = '{801,  800,  0, 0, 1, 0, 0,    0, 0, 0};
    rows[3]  = '{840,  839,  0, 0, 1, 0, 0,    0, 0, 0};
    rows[4]  = '{841,  840,  0, 0, 1, 0, !DLY, 0, 0, 0};
    rows[5]  = '{842,  841,  0, 0, 1, 0, 1,    0, 0, 0};
    rows[6]  = '{968,  967,  0, 0, 1, 0, 1,    0, 0, 0};
    rows[7]  = '{969,  968,  0, 0, 1, 0, DLY,  0, 0, 0};
    rows[8]  = '{970,  969,  0, 0, 1, 0, 0,    0, 0, 0};
    rows[9]  = '{1055, 1054, 0, 0, 1, 0, 0,    0, 0, 0};
    rows[10] = '{1056, 1055, 0, 0, 1, 0, 0,    0, 1, 0};
    rows[11] = '{1057, 0,    1, 1, 0, 0, 0,    0, 0, 0};
    exp_q.push_back(32'(S_FRAME));
    exp_q.push_back(32'(2 * S_FRAME));

    // Reset held for 5 clocks.
    reset_n = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("rst.d_h", d_h, 1055);   check("rst.d_v", d_v, 627);
    check("rst.d_de", d_de, 0);    check("rst.d_hb", d_hb, 1);
    check("rst.d_vb", d_vb, 1);    check("rst.d_hs", d_hs, 0);
    check("rst.d_vs", d_vs, 0);    check("rst.d_nv", d_nv, 0);
    check("rst.d_nf", d_nf, 0);
    check("rst.s_h", s_h, 31);     check("rst.s_v", s_v, 17);
    check("rst.s_hs", s_hs, 1);    check("rst.s_vs", s_vs, 0);
    check("rst.s_de", s_de, 0);    check("rst.s_nf", s_nf, 0);
    scan_en = 1'b1;
    agg_on  = 1'b1;
    reset_n = 1'b1;

    // First line of the default raster.
    for (int i = 0; i < 12; i++) begin
      wait_k(rows[i].k);
      check($sformatf("row%0d.h", i), d_h, rows[i].h);
      check($sformatf("row%0d.v", i), d_v, rows[i].v);
      check($sformatf("row%0d.de", i), d_de, rows[i].de);
      check($sformatf("row%0d.hb", i), d_hb, rows[i].hb);
      check($sformatf("row%0d.vb", i), d_vb, rows[i].vb);
      check($sformatf("row%0d.hs", i), d_hs, rows[i].hs);
      check($sformatf("row%0d.vs", i), d_vs, rows[i].vs);
      check($sformatf("row%0d.nv", i), d_nv, rows[i].nv);
      check($sformatf("row%0d.nf", i), d_nf, rows[i].nf);
    end

    // Two full frames of the small raster.
    wait_k(2 * S_FRAME + 1);
    agg_on = 1'b0;
    check("agg.nf", agg_nf, 2);
    check("agg.nv", agg_nv, 2 * S_VT);
    check("agg.de", agg_de, 2 * 16 * 12);
    check("agg.vs", agg_vs, 2 * 2 * S_HT);
    check("agg.hs", agg_hs, 2 * 8 * S_VT);
    check("agg.nf_q_size", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check("agg.nf_time", got_q.pop_front(), exp_q.pop_front());

    // Frame wrap of the small raster.
    wait_k(3 * S_FRAME);
    check("wrap.h", s_h, S_HT - 1);  check("wrap.v", s_v, S_VT - 1);
    check("wrap.nv", s_nv, 1);       check("wrap.nf", s_nf, 1);
    wait_k(3 * S_FRAME + 1);
    check("wrap1.h", s_h, 0);        check("wrap1.v", s_v, 0);
    check("wrap1.vb", s_vb, 0);      check("wrap1.nf", s_nf, 0);

    // Asynchronous reset inside hsync and vsync at (24,13).
    wait_k(3 * S_FRAME + 13 * S_HT + 24 + 1);
    check("mid.h", s_h, 24);         check("mid.v", s_v, 13);
    check("mid.hs_act", s_hs, 0);    check("mid.vs_act", s_vs, 1);
    #1 reset_n = 1'b0;
    #1;
    check("mid.hs_off", s_hs, 1);    check("mid.vs_off", s_vs, 0);
    check("mid.h_rst", s_h, 31);     check("mid.v_rst", s_v, 17);
    check("mid.d_h_rst", d_h, 1055); check("mid.d_de_rst", d_de, 0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    wait_k(1);
    check("restart.s_h", s_h, 0);    check("restart.s_v", s_v, 0);
    check("restart.d_h", d_h, 0);    check("restart.d_de", d_de, 1);

    // Random reset placement and run lengths.
    for (int it = 0; it < 25; it++) begin
      int hold, run, off;
      run = $urandom_range(20, 2500);
      wait_k(run);
      e = ref_at(SP, k);
      check("rnd.s_h", s_h, e.h);
      check("rnd.s_v", s_v, e.v);
      off = $urandom_range(0, 1);
      #(off) reset_n = 1'b0;
      #1;
      check("rnd.d_h_rst", d_h, 1055);
      check("rnd.s_v_rst", s_v, 17);
      hold = $urandom_range(1, 4);
      repeat (hold) @(posedge clk);
      #2 reset_n = 1'b1;
    end
    wait_k(50);

    check("scan.diffs", scan_err, 0);
    check("scan.ran", scan_n > 1000, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
